// File: rtl/hop_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hop_pkg : shared encodings for the hop sprite controller             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOP  = 2'd1,
        ST_DEAD = 2'd2,
        ST_OVER = 2'd3
    } hop_state_e;

    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_DOWN  = 2'd1;
    localparam logic [1:0] c_DIR_RIGHT = 2'd2;
    localparam logic [1:0] c_DIR_LEFT  = 2'd3;

    // Button bit positions inside i_btn_n = {left, right, down, up}
    localparam int c_BTN_UP    = 0;
    localparam int c_BTN_DOWN  = 1;
    localparam int c_BTN_RIGHT = 2;
    localparam int c_BTN_LEFT  = 3;

    localparam int c_ROW_W = 5;

endpackage
`default_nettype wire

// File: rtl/hop_press_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hop_press_detect : tick-qualified button edges, up>down>right>left   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hop_press_detect
    import hop_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic [3:0] i_btn_n,
    output logic       o_press_valid,
    output logic [1:0] o_dir
);

    logic [3:0] r_held_q;
    logic [3:0] w_held_d;
    logic [3:0] w_pressed;
    logic [3:0] w_edge;

    always_comb begin
        w_pressed     = ~i_btn_n;
        w_held_d      = i_tick ? w_pressed : r_held_q;
        w_edge        = i_tick ? (w_pressed & ~r_held_q) : 4'b0000;
        o_press_valid = |w_edge;
        o_dir         = c_DIR_UP;
        if (w_edge[c_BTN_UP]) begin
            o_dir = c_DIR_UP;
        end else if (w_edge[c_BTN_DOWN]) begin
            o_dir = c_DIR_DOWN;
        end else if (w_edge[c_BTN_RIGHT]) begin
            o_dir = c_DIR_RIGHT;
        end else if (w_edge[c_BTN_LEFT]) begin
            o_dir = c_DIR_LEFT;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_held_q <= 4'b0000;
        end else begin
            r_held_q <= w_held_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hop_sprite_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hop_sprite_ctrl : animated, bounds-checked player hops with lives    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hop_sprite_ctrl
    import hop_pkg::*;
#(
    parameter int CW             = 12,
    parameter int H_WIDTH        = 11,
    parameter int H_HEIGHT       = 11,
    parameter int IX             = 320,
    parameter int IY             = 469,
    parameter int HOP_DIS        = 48,
    parameter int STEP           = 4,
    parameter int X_MIN          = 11,
    parameter int X_MAX          = 628,
    parameter int Y_MIN          = 24,
    parameter int Y_MAX          = 469,
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ani_stb,
    input  logic          i_animate,
    input  logic [3:0]    i_btn_n,
    input  logic          i_dead,
    input  logic          i_restart,
    output logic [CW-1:0] o_x1,
    output logic [CW-1:0] o_x2,
    output logic [CW-1:0] o_y1,
    output logic [CW-1:0] o_y2,
    output logic          o_hopping,
    output logic [1:0]    o_dir,
    output logic [2:0]    o_lives,
    output logic          o_game_over,
    output logic [4:0]    o_max_row
);

    localparam int c_TMR_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;

    localparam logic [CW:0]          c_HOP      = (CW+1)'(HOP_DIS);
    localparam logic [CW:0]          c_XMIN     = (CW+1)'(X_MIN);
    localparam logic [CW:0]          c_XMAX     = (CW+1)'(X_MAX);
    localparam logic [CW:0]          c_YMIN     = (CW+1)'(Y_MIN);
    localparam logic [CW:0]          c_YMAX     = (CW+1)'(Y_MAX);
    localparam logic [CW-1:0]        c_STEP     = CW'(STEP);
    localparam logic [CW-1:0]        c_IX       = CW'(IX);
    localparam logic [CW-1:0]        c_IY       = CW'(IY);
    localparam logic [CW-1:0]        c_HW       = CW'(H_WIDTH);
    localparam logic [CW-1:0]        c_HH       = CW'(H_HEIGHT);
    localparam logic [2:0]           c_LIVES    = 3'(LIVES);
    localparam logic [c_TMR_W-1:0]   c_TMR_LOAD = c_TMR_W'(RESPAWN_FRAMES - 1);
    localparam logic [c_ROW_W-1:0]   c_ROW_TOP  = '1;

    if (((HOP_DIS % STEP) != 0) || (LIVES < 1) || (LIVES > 7)) begin : g_bad_params
        $error("hop_sprite_ctrl: HOP_DIS must be a multiple of STEP and LIVES in 1..7");
    end

    hop_state_e         r_state_q, w_state_d;
    logic [CW-1:0]      r_x_q, w_x_d, r_y_q, w_y_d;
    logic [CW-1:0]      r_tx_q, w_tx_d, r_ty_q, w_ty_d;
    logic [1:0]         r_dir_q, w_dir_d;
    logic               r_hop_q, w_hop_d;
    logic [2:0]         r_lives_q, w_lives_d;
    logic [c_ROW_W-1:0] r_row_q, w_row_d, r_max_q, w_max_d;
    logic [c_TMR_W-1:0] r_tmr_q, w_tmr_d;
    logic               r_qv_q, w_qv_d;
    logic [1:0]         r_qdir_q, w_qdir_d;

    logic               w_tick;
    logic               w_press_valid;
    logic [1:0]         w_press_dir;
    logic               w_lreq;
    logic [1:0]         w_ldir;
    logic [CW:0]        w_cx, w_cy, w_tgx, w_tgy;
    logic               w_legal;
    logic [CW-1:0]      w_nx, w_ny;
    logic [c_ROW_W-1:0] w_row_up;

    assign w_tick = i_animate & i_ani_stb;

    hop_press_detect u_press (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_tick        (w_tick),
        .i_btn_n       (i_btn_n),
        .o_press_valid (w_press_valid),
        .o_dir         (w_press_dir)
    );

    // Launch candidate: a queued move beats a fresh press; the extra MSB catches underflow.
    always_comb begin
        w_lreq = r_qv_q | w_press_valid;
        w_ldir = r_qv_q ? r_qdir_q : w_press_dir;
        w_cx   = {1'b0, r_x_q};
        w_cy   = {1'b0, r_y_q};
        w_tgx  = w_cx;
        w_tgy  = w_cy;
        unique case (w_ldir)
            c_DIR_UP:    w_tgy = w_cy - c_HOP;
            c_DIR_DOWN:  w_tgy = w_cy + c_HOP;
            c_DIR_RIGHT: w_tgx = w_cx + c_HOP;
            default:     w_tgx = w_cx - c_HOP;
        endcase
        w_legal = (w_tgx >= c_XMIN) && (w_tgx <= c_XMAX) &&
                  (w_tgy >= c_YMIN) && (w_tgy <= c_YMAX);
    end

    always_comb begin
        w_nx = r_x_q;
        w_ny = r_y_q;
        if (r_x_q < r_tx_q) begin
            w_nx = r_x_q + c_STEP;
        end else if (r_x_q > r_tx_q) begin
            w_nx = r_x_q - c_STEP;
        end
        if (r_y_q < r_ty_q) begin
            w_ny = r_y_q + c_STEP;
        end else if (r_y_q > r_ty_q) begin
            w_ny = r_y_q - c_STEP;
        end
        w_row_up = (r_row_q == c_ROW_TOP) ? r_row_q : r_row_q + c_ROW_W'(1);
    end

    always_comb begin
        w_state_d = r_state_q;
        w_x_d     = r_x_q;
        w_y_d     = r_y_q;
        w_tx_d    = r_tx_q;
        w_ty_d    = r_ty_q;
        w_dir_d   = r_dir_q;
        w_hop_d   = r_hop_q;
        w_lives_d = r_lives_q;
        w_row_d   = r_row_q;
        w_max_d   = r_max_q;
        w_tmr_d   = r_tmr_q;
        w_qv_d    = r_qv_q;
        w_qdir_d  = r_qdir_q;
        if (w_tick) begin
            unique case (r_state_q)
                ST_IDLE, ST_HOP: begin
                    if (i_dead) begin
                        w_x_d     = c_IX;
                        w_y_d     = c_IY;
                        w_tx_d    = c_IX;
                        w_ty_d    = c_IY;
                        w_qv_d    = 1'b0;
                        w_row_d   = '0;
                        w_hop_d   = 1'b0;
                        w_lives_d = r_lives_q - 3'd1;
                        w_tmr_d   = c_TMR_LOAD;
                        w_state_d = ST_DEAD;
                    end else if (r_state_q == ST_IDLE) begin
                        if (w_lreq) begin
                            w_qv_d = 1'b0;
                            if (w_legal) begin
                                w_tx_d    = w_tgx[CW-1:0];
                                w_ty_d    = w_tgy[CW-1:0];
                                w_dir_d   = w_ldir;
                                w_hop_d   = 1'b1;
                                w_state_d = ST_HOP;
                            end
                        end
                    end else begin
                        w_x_d = w_nx;
                        w_y_d = w_ny;
                        if (w_press_valid && !r_qv_q) begin
                            w_qv_d   = 1'b1;
                            w_qdir_d = w_press_dir;
                        end
                        if ((w_nx == r_tx_q) && (w_ny == r_ty_q)) begin
                            w_hop_d   = 1'b0;
                            w_state_d = ST_IDLE;
                            if (r_dir_q == c_DIR_UP) begin
                                w_row_d = w_row_up;
                                if (w_row_up > r_max_q) begin
                                    w_max_d = w_row_up;
                                end
                            end else if ((r_dir_q == c_DIR_DOWN) && (r_row_q != '0)) begin
                                w_row_d = r_row_q - c_ROW_W'(1);
                            end
                        end
                    end
                end
                ST_DEAD: begin
                    if (r_tmr_q == '0) begin
                        w_state_d = (r_lives_q != 3'd0) ? ST_IDLE : ST_OVER;
                    end else begin
                        w_tmr_d = r_tmr_q - c_TMR_W'(1);
                    end
                end
                default: begin
                    if (i_restart) begin
                        w_lives_d = c_LIVES;
                        w_max_d   = '0;
                        w_state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q <= ST_IDLE;
            r_x_q     <= c_IX;
            r_y_q     <= c_IY;
            r_tx_q    <= c_IX;
            r_ty_q    <= c_IY;
            r_dir_q   <= c_DIR_UP;
            r_hop_q   <= 1'b0;
            r_lives_q <= c_LIVES;
            r_row_q   <= '0;
            r_max_q   <= '0;
            r_tmr_q   <= '0;
            r_qv_q    <= 1'b0;
            r_qdir_q  <= c_DIR_UP;
        end else begin
            r_state_q <= w_state_d;
            r_x_q     <= w_x_d;
            r_y_q     <= w_y_d;
            r_tx_q    <= w_tx_d;
            r_ty_q    <= w_ty_d;
            r_dir_q   <= w_dir_d;
            r_hop_q   <= w_hop_d;
            r_lives_q <= w_lives_d;
            r_row_q   <= w_row_d;
            r_max_q   <= w_max_d;
            r_tmr_q   <= w_tmr_d;
            r_qv_q    <= w_qv_d;
            r_qdir_q  <= w_qdir_d;
        end
    end

    assign o_x1        = r_x_q - c_HW;
    assign o_x2        = r_x_q + c_HW;
    assign o_y1        = r_y_q - c_HH;
    assign o_y2        = r_y_q + c_HH;
    assign o_hopping   = r_hop_q;
    assign o_dir       = r_dir_q;
    assign o_lives     = r_lives_q;
    assign o_game_over = (r_state_q == ST_OVER);
    assign o_max_row   = r_max_q;

endmodule
`default_nettype wire

// File: tb/tb_hop_sprite_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hop_sprite_ctrl : scoreboard bench for hop_sprite_ctrl            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hop_sprite_ctrl;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_ani_stb;
    logic        i_animate;
    logic [3:0]  i_btn_n;
    logic        i_dead;
    logic        i_restart;
    logic [11:0] o_x1, o_x2, o_y1, o_y2;
    logic        o_hopping;
    logic [1:0]  o_dir;
    logic [2:0]  o_lives;
    logic        o_game_over;
    logic [4:0]  o_max_row;

    localparam logic [3:0] c_NONE  = 4'b1111;
    localparam logic [3:0] c_UP    = 4'b1110;
    localparam logic [3:0] c_DOWN  = 4'b1101;
    localparam logic [3:0] c_RIGHT = 4'b1011;
    localparam logic [3:0] c_LEFT  = 4'b0111;

    hop_sprite_ctrl u_dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_ani_stb   (i_ani_stb),
        .i_animate   (i_animate),
        .i_btn_n     (i_btn_n),
        .i_dead      (i_dead),
        .i_restart   (i_restart),
        .o_x1        (o_x1),
        .o_x2        (o_x2),
        .o_y1        (o_y1),
        .o_y2        (o_y2),
        .o_hopping   (o_hopping),
        .o_dir       (o_dir),
        .o_lives     (o_lives),
        .o_game_over (o_game_over),
        .o_max_row   (o_max_row)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string nm;
        int    x;
        int    y;
        int    hop;
        int    dir;
        int    lives;
        int    go;
        int    mrow;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   cyc_cnt  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Hand-tracked expected player state after the next checked tick
    int ex = 320, ey = 469, ehop = 0, edir = 0, elives = 3, ego = 0, emax = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compares every expectation whose sample cycle has arrived
    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
            m_e = exp_q.pop_front();
            n_checks++;
            if (m_e.cyc != cyc_cnt) begin
                n_fail++;
                $display("FAIL %s: sampled at cycle %0d, required cycle %0d", m_e.nm, cyc_cnt, m_e.cyc);
            end else if (int'(o_x1) != m_e.x - 11 || int'(o_x2) != m_e.x + 11 ||
                         int'(o_y1) != m_e.y - 11 || int'(o_y2) != m_e.y + 11 ||
                         int'(o_hopping) != m_e.hop || int'(o_dir) != m_e.dir ||
                         int'(o_lives) != m_e.lives || int'(o_game_over) != m_e.go ||
                         int'(o_max_row) != m_e.mrow) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got box=%0d,%0d,%0d,%0d hop=%0d dir=%0d lives=%0d go=%0d max=%0d; expected box=%0d,%0d,%0d,%0d hop=%0d dir=%0d lives=%0d go=%0d max=%0d",
                         m_e.nm, cyc_cnt, o_x1, o_x2, o_y1, o_y2, o_hopping, o_dir, o_lives, o_game_over, o_max_row,
                         m_e.x - 11, m_e.x + 11, m_e.y - 11, m_e.y + 11, m_e.hop, m_e.dir, m_e.lives, m_e.go, m_e.mrow);
            end
        end
    end

    task automatic push(input string nm, input int at);
        exp_t e;
        e.cyc = at;  e.nm = nm;   e.x = ex;        e.y = ey;   e.hop = ehop;
        e.dir = edir; e.lives = elives; e.go = ego; e.mrow = emax;
        exp_q.push_back(e);
    endtask

    // One strobe cycle followed by one quiet cycle; buttons stay as driven
    task automatic tick(input string nm, input logic [3:0] b, input logic d, input logic r, input bit chk);
        i_btn_n   = b;
        i_dead    = d;
        i_restart = r;
        i_ani_stb = 1'b1;
        if (chk) push(nm, cyc_cnt + 1);
        @(posedge clk); #1;
        i_ani_stb = 1'b0;
        i_dead    = 1'b0;
        i_restart = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_ani_stb = 1'b0;
        i_animate = 1'b1;
        i_btn_n   = c_NONE;
        i_dead    = 1'b0;
        i_restart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        push("reset_state", cyc_cnt);
        @(posedge clk); #1;

        // Held up button: exactly one hop 469 -> 421 over 12 ticks
        ehop = 1;
        tick("up_launch", c_UP, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            ey = 469 - 4 * k;
            ehop = (k != 12) ? 1 : 0;
            if (k == 12) emax = 1;
            tick("up_move", c_UP, 1'b0, 1'b0, 1'b1);
        end
        for (int k = 0; k < 7; k++) tick("up_held_no_repeat", c_UP, 1'b0, 1'b0, 1'b1);
        tick("up_release", c_NONE, 1'b0, 1'b0, 1'b1);

        // Queue: right at hop tick 3 is stored, left at tick 5 is dropped
        ehop = 1;
        tick("q_up_launch", c_UP, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            ey = 421 - 4 * k;
            ehop = (k != 12) ? 1 : 0;
            if (k == 12) emax = 2;
            tick("q_up_move", (k == 3) ? c_RIGHT : (k == 5) ? c_LEFT : c_NONE, 1'b0, 1'b0, 1'b1);
        end
        ehop = 1;
        edir = 2;
        tick("q_right_launch", c_NONE, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            ex = 320 + 4 * k;
            ehop = (k != 12) ? 1 : 0;
            tick("q_right_move", c_NONE, 1'b0, 1'b0, 1'b1);
        end
        tick("q_left_was_dropped", c_NONE, 1'b0, 1'b0, 1'b1);

        // Freeze with i_animate low, then asynchronous reset mid-hop
        ehop = 1;
        edir = 0;
        tick("d_launch", c_UP, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 2; k++) begin
            ey = 373 - 4 * k;
            tick("d_move", c_NONE, 1'b0, 1'b0, 1'b1);
        end
        i_animate = 1'b0;
        for (int k = 0; k < 3; k++) tick("no_anim_frozen", c_NONE, 1'b0, 1'b0, 1'b1);
        i_rst_n = 1'b0;
        ex = 320; ey = 469; ehop = 0; edir = 0; elives = 3; ego = 0; emax = 0;
        push("async_reset", cyc_cnt);
        @(posedge clk); #1;
        i_rst_n   = 1'b1;
        i_animate = 1'b1;

        // Bounds: down from spawn illegal; left hops stop at x=32
        tick("down_blocked", c_DOWN, 1'b0, 1'b0, 1'b1);
        tick("release", c_NONE, 1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 6; n++) begin
            ehop = 1;
            edir = 3;
            tick("left_launch", c_LEFT, 1'b0, 1'b0, 1'b1);
            for (int k = 1; k <= 12; k++) begin
                ex = 320 - 48 * (n - 1) - 4 * k;
                ehop = (k != 12) ? 1 : 0;
                tick("left_land", c_NONE, 1'b0, 1'b0, (k == 12));
            end
        end
        tick("left_reject_underflow", c_LEFT, 1'b0, 1'b0, 1'b1);
        tick("release", c_NONE, 1'b0, 1'b0, 1'b0);

        // Death at tick 6 of an up hop, then 60 DEAD ticks
        ehop = 1;
        edir = 0;
        tick("f_launch", c_UP, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            ey = 469 - 4 * k;
            tick("f_move", c_UP, 1'b0, 1'b0, (k == 5));
        end
        ex = 320; ey = 469; ehop = 0; elives = 2;
        tick("death1", c_NONE, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 59; k++) tick("dead_wait", c_UP, 1'b0, 1'b0, (k == 30));
        tick("dead_ignores_i_dead", c_UP, 1'b1, 1'b0, 1'b1);
        tick("held_no_fire", c_UP, 1'b0, 1'b0, 1'b1);
        tick("release", c_NONE, 1'b0, 1'b0, 1'b0);

        // Full hop, restart ignored outside OVER, then two more deaths
        ehop = 1;
        tick("g_launch", c_UP, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            ey = 469 - 4 * k;
            ehop = (k != 12) ? 1 : 0;
            if (k == 12) emax = 1;
            tick("g_land", c_NONE, 1'b0, 1'b0, (k == 12));
        end
        tick("restart_ignored", c_NONE, 1'b0, 1'b1, 1'b1);
        ey = 469;
        elives = 1;
        tick("death2", c_NONE, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 60; k++) tick("dead_wait", c_NONE, 1'b0, 1'b0, 1'b0);
        elives = 0;
        tick("death3", c_NONE, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 59; k++) tick("last_dead_tick", c_NONE, 1'b0, 1'b0, (k == 59));
        ego = 1;
        tick("game_over", c_NONE, 1'b0, 1'b0, 1'b1);
        tick("over_no_move", c_UP, 1'b0, 1'b0, 1'b1);
        tick("over_ignores_dead", c_NONE, 1'b1, 1'b0, 1'b1);
        elives = 3; emax = 0; ego = 0;
        tick("restart", c_NONE, 1'b0, 1'b1, 1'b1);
        ehop = 1;
        tick("post_restart_hop", c_UP, 1'b0, 1'b0, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        while (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never sampled, required at cycle %0d (now %0d)", m_e.nm, m_e.cyc, cyc_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
